// File: rtl/mask_pkg.sv
// mask_pkg -- shared definitions for the double-buffered mask BRAM controller.
//
// Contents:
//   swap_state_t   : bank-swap FSM states (IDLE, ARMED)
//   BYTES_PER_WORD : byte stride of one 32-bit BRAM word
//   word_byte_addr : maps {bank, word index} to a BRAM byte address
//
// Optional feature macro used by the controller: MASK_BRAM_CTRL_STATS_EN.

package mask_pkg;

    // IDLE: no swap requested.
    // ARMED: a commit was seen and the swap waits for the next frame start.
    typedef enum logic {
        IDLE,
        ARMED
    } swap_state_t;

    localparam int BYTES_PER_WORD = 4;

    // The bank bit sits directly above the AW-bit word index, and the
    // resulting word number is scaled to a byte address.
    function automatic logic [31:0] word_byte_addr(input logic        bank,
                                                   input logic [31:0] index,
                                                   input int          aw);
        logic [31:0] word_num;
        word_num = index | (32'(bank) << aw);
        return word_num * 32'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/mask_bram_ctrl.sv
// mask_bram_ctrl -- double-buffered pixel mask store in a single BRAM port.
//
// The pixel stream reads one mask word per accepted beat from the active
// bank. The host writes new mask words into the inactive bank whenever the
// stream leaves the port free, then pulses host_commit; the banks swap at
// the next start-of-frame beat, so a frame never sees a half-written mask.
//
// Parameters:
//   DW          : mask word width (low bits of each 32-bit BRAM word)
//   FRAME_WORDS : mask words per bank (pixels per frame)
//   AW          : word index width, 2^AW >= FRAME_WORDS
//
// Ports:
//   clk, rst                         : clock, async active-high reset
//   pix_tvalid/pix_tready/pix_tuser  : snooped pixel stream handshake + SOF
//   host_wvalid/host_wready          : mask write handshake
//   host_waddr, host_wdata           : mask write index and data
//   host_commit                      : pulse, swap banks at next SOF
//   commit_pending                   : swap armed but not yet taken
//   active_bank                      : bank read by the stream
//   addr_err                         : sticky out-of-range write flag
//   bram_en/bram_we/bram_addr/bram_din : BRAM port (byte addressed)
//   stall_cnt, frame_cnt             : only with MASK_BRAM_CTRL_STATS_EN;
//                                      saturating write-stall and SOF counts

module mask_bram_ctrl
    import mask_pkg::*;
#(
    parameter int DW          = 16,
    parameter int FRAME_WORDS = 307200,
    parameter int AW          = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_tvalid,
    input  logic          pix_tready,
    input  logic          pix_tuser,
    input  logic          host_wvalid,
    output logic          host_wready,
    input  logic [AW-1:0] host_waddr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_commit,
    output logic          commit_pending,
    output logic          active_bank,
    output logic          addr_err,
    output logic          bram_en,
    output logic          bram_we,
    output logic [31:0]   bram_addr,
    output logic [31:0]   bram_din
`ifdef MASK_BRAM_CTRL_STATS_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   frame_cnt
`endif
);

    logic          beat;
    logic          sof_beat;
    logic          wr_accept;
    logic          wr_in_range;
    logic          swap;
    logic          bank_eff;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] ridx;
    logic [31:0]   addr_q;
    logic          active_bank_q;
    logic          commit_pending_q;
    logic          addr_err_q;
    swap_state_t   state_q;
    swap_state_t   state_d;

    assign beat        = pix_tvalid & pix_tready;
    assign sof_beat    = beat & pix_tuser;
    assign host_wready = ~beat;
    assign wr_accept   = host_wvalid & host_wready;
    assign wr_in_range = 32'(host_waddr) < 32'(FRAME_WORDS);

    // The SOF beat that takes an armed swap must already read the new bank,
    // so the read path uses the bank as it will be after this cycle.
    assign swap     = (state_q == ARMED) & sof_beat;
    assign bank_eff = active_bank_q ^ swap;
    assign ridx     = pix_tuser ? '0 : idx_q;

    assign bram_en        = 1'b1;
    assign active_bank    = active_bank_q;
    assign commit_pending = commit_pending_q;
    assign addr_err       = addr_err_q;

    // BRAM port mux. The stream always wins; a host write only gets the port
    // in cycles without a beat, and always lands in the bank the stream is
    // not reading. Out-of-range writes are swallowed without touching the
    // port, and an idle cycle leaves the last address on the bus.
    always_comb begin
        bram_we   = 1'b0;
        bram_addr = addr_q;
        bram_din  = 32'(host_wdata);
        if (beat) begin
            bram_addr = word_byte_addr(bank_eff, 32'(ridx), AW);
        end else if (wr_accept && wr_in_range) begin
            bram_we   = 1'b1;
            bram_addr = word_byte_addr(~active_bank_q, 32'(host_waddr), AW);
        end
    end

    // Swap FSM next state. A commit in IDLE arms the swap even when it
    // coincides with a SOF beat, which deliberately defers the swap to the
    // following frame. Commits while armed change nothing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (host_commit) state_d = ARMED;
            ARMED:   if (sof_beat)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Swap FSM state, the visible bank and the pending flag. The outputs
    // change one cycle after the SOF beat that takes the swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            active_bank_q    <= 1'b0;
            commit_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            commit_pending_q <= (state_d == ARMED);
            if (swap) begin
                active_bank_q <= ~active_bank_q;
            end
        end
    end

    // Frame position tracker. Each beat advances past the word just read,
    // wrapping at the end of the frame; a SOF beat restarts from word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (beat) begin
            if (ridx == AW'(FRAME_WORDS - 1)) begin
                idx_q <= '0;
            end else begin
                idx_q <= ridx + AW'(1);
            end
        end
    end

    // Address hold register so idle cycles keep the previous BRAM address,
    // plus the sticky out-of-range flag that only reset clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            addr_q <= bram_addr;
            if (wr_accept && !wr_in_range) begin
                addr_err_q <= 1'b1;
            end
        end
    end

`ifdef MASK_BRAM_CTRL_STATS_EN
    // Saturating statistics: cycles where the host waited on the stream,
    // and the number of SOF beats seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            if (host_wvalid && !host_wready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (sof_beat && (frame_cnt != '1)) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mask_bram_ctrl.sv
// tb_mask_bram_ctrl -- scoreboard bench for mask_bram_ctrl.
//
// Uses a small frame (6 words, 3-bit index) so wrap and out-of-range
// addresses are reachable. Stimulus pushes the expected per-cycle response
// of a frame/bank reference model into a queue; a monitor process pops and
// compares on every cycle that has an entry. Stats outputs are compared when
// MASK_BRAM_CTRL_STATS_EN is defined.

module tb_mask_bram_ctrl;

    localparam int DW = 16;
    localparam int FW = 6;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          pix_tvalid;
    logic          pix_tready;
    logic          pix_tuser;
    logic          host_wvalid;
    logic          host_wready;
    logic [AW-1:0] host_waddr;
    logic [DW-1:0] host_wdata;
    logic          host_commit;
    logic          commit_pending;
    logic          active_bank;
    logic          addr_err;
    logic          bram_en;
    logic          bram_we;
    logic [31:0]   bram_addr;
    logic [31:0]   bram_din;
`ifdef MASK_BRAM_CTRL_STATS_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   frame_cnt;
`endif

    mask_bram_ctrl #(
        .DW(DW),
        .FRAME_WORDS(FW),
        .AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_tvalid(pix_tvalid),
        .pix_tready(pix_tready),
        .pix_tuser(pix_tuser),
        .host_wvalid(host_wvalid),
        .host_wready(host_wready),
        .host_waddr(host_waddr),
        .host_wdata(host_wdata),
        .host_commit(host_commit),
        .commit_pending(commit_pending),
        .active_bank(active_bank),
        .addr_err(addr_err),
        .bram_en(bram_en),
        .bram_we(bram_we),
        .bram_addr(bram_addr),
        .bram_din(bram_din)
`ifdef MASK_BRAM_CTRL_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .frame_cnt(frame_cnt)
`endif
    );

    typedef struct {
        logic        wready;
        logic        we;
        logic        addr_known;
        logic [31:0] addr;
        logic [31:0] din;
        logic        bank;
        logic        pend;
        logic        err;
        logic [31:0] stall;
        logic [31:0] frames;
    } exp_t;

    exp_t sb_q[$];

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: position within the frame, visible bank,
    // whether a swap is waiting, sticky error, and the address left on the
    // bus by the last real access.
    int          m_pos;
    int          m_bank;
    bit          m_armed;
    bit          m_err;
    bit          m_addr_known;
    int unsigned m_last_addr;
    int unsigned m_stall;
    int unsigned m_frames;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one field against the model and record the outcome.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push the response the model predicts.
    task automatic applyStimulus(input bit tv, input bit tr, input bit tu,
                                 input bit wv, input int waddr,
                                 input int wdata, input bit commit);
        exp_t e;
        bit   beat;
        bit   sof;
        int   ridx;
        int   bank_eff;
        @(posedge clk);
        #2;
        pix_tvalid  = tv;
        pix_tready  = tr;
        pix_tuser   = tu;
        host_wvalid = wv;
        host_waddr  = AW'(waddr);
        host_wdata  = DW'(wdata);
        host_commit = commit;

        beat = tv && tr;
        sof  = beat && tu;
        ridx = tu ? 0 : m_pos;

        e.wready     = !beat;
        e.we         = 1'b0;
        e.din        = 32'(wdata & 32'hFFFF);
        e.bank       = m_bank[0];
        e.pend       = m_armed;
        e.err        = m_err;
        e.stall      = m_stall;
        e.frames     = m_frames;
        e.addr_known = m_addr_known;
        e.addr       = m_last_addr;

        if (beat) begin
            bank_eff       = (m_armed && sof) ? 1 - m_bank : m_bank;
            e.addr         = (bank_eff * (1 << AW) + ridx) * 4;
            e.addr_known   = 1'b1;
            m_last_addr    = e.addr;
            m_addr_known   = 1'b1;
            m_pos          = (ridx + 1) % FW;
            if (wv) m_stall++;
        end else if (wv) begin
            if (waddr < FW) begin
                e.we         = 1'b1;
                e.addr       = ((1 - m_bank) * (1 << AW) + waddr) * 4;
                e.addr_known = 1'b1;
                m_last_addr  = e.addr;
                m_addr_known = 1'b1;
            end else begin
                e.addr_known = 1'b0;
                m_addr_known = 1'b0;
                m_err        = 1'b1;
            end
        end
        sb_q.push_back(e);

        if (m_armed && sof) begin
            m_bank  = 1 - m_bank;
            m_armed = 1'b0;
        end else if (!m_armed && commit) begin
            m_armed = 1'b1;
        end
        if (sof) m_frames++;
    endtask

    // Assert reset with idle inputs, expect the cleared state while it is
    // held, and put the model back to its power-up state.
    task automatic applyReset();
        exp_t e;
        @(posedge clk);
        #2;
        rst         = 1'b1;
        pix_tvalid  = 1'b0;
        pix_tready  = 1'b0;
        pix_tuser   = 1'b0;
        host_wvalid = 1'b0;
        host_commit = 1'b0;
        m_pos        = 0;
        m_bank       = 0;
        m_armed      = 1'b0;
        m_err        = 1'b0;
        m_addr_known = 1'b1;
        m_last_addr  = 0;
        m_stall      = 0;
        m_frames     = 0;
        e.wready     = 1'b1;
        e.we         = 1'b0;
        e.addr_known = 1'b1;
        e.addr       = 32'd0;
        e.din        = 32'd0;
        e.bank       = 1'b0;
        e.pend       = 1'b0;
        e.err        = 1'b0;
        e.stall      = 32'd0;
        e.frames     = 32'd0;
        sb_q.push_back(e);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle,
    // away from the clock edge that updates the DUT registers.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("host_wready", 32'(host_wready), 32'(e.wready));
                checkOutput("bram_en", 32'(bram_en), 32'd1);
                checkOutput("bram_we", 32'(bram_we), 32'(e.we));
                if (e.addr_known) checkOutput("bram_addr", bram_addr, e.addr);
                if (e.we) checkOutput("bram_din", bram_din, e.din);
                checkOutput("active_bank", 32'(active_bank), 32'(e.bank));
                checkOutput("commit_pending", 32'(commit_pending), 32'(e.pend));
                checkOutput("addr_err", 32'(addr_err), 32'(e.err));
`ifdef MASK_BRAM_CTRL_STATS_EN
                checkOutput("stall_cnt", stall_cnt, e.stall);
                checkOutput("frame_cnt", frame_cnt, e.frames);
`endif
            end
        end
    end

    // Directed scenarios first, then a randomized soak with an occasional
    // reset, then drain the scoreboard and report.
    initial begin
        rst         = 1'b0;
        pix_tvalid  = 1'b0;
        pix_tready  = 1'b0;
        pix_tuser   = 1'b0;
        host_wvalid = 1'b0;
        host_waddr  = '0;
        host_wdata  = '0;
        host_commit = 1'b0;

        $display("[TB] reset state");
        applyReset();

        $display("[TB] host write into inactive bank on idle stream");
        applyStimulus(0, 0, 0, 1, 5, 16'h00FF, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] read index wrap over a frame");
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);

        $display("[TB] host write against continuous stream");
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 1, i, 16'hA500 + i, 0);
        applyStimulus(1, 0, 0, 1, 2, 16'h1234, 0);

        $display("[TB] commit mid-frame then swap at SOF");
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 3, 16'hBEEF, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);

        $display("[TB] commit coinciding with SOF defers the swap");
        applyStimulus(1, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 0, 16'h0001, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] out-of-range write and reset mid-frame");
        applyStimulus(0, 0, 0, 1, FW, 16'hDEAD, 0);
        applyStimulus(0, 0, 0, 1, 7, 16'hDEAD, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyReset();
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (i == 250) begin
                applyReset();
            end
            applyStimulus($urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 16'hFFFF)),
                          $urandom_range(0, 19) == 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
